operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Decode/operand-fetch stage sitting directly around the regfile.
//  - Takes instructions from fetch on a valid/ready handshake and drives the regfile read addresses.
//  - Captures the regfile's registered read data one cycle later.
//  - Repairs the regfile's missing write-to-read bypass.
//  - Hands {pc, inst, rs1, rs2} to execute on a second valid/ready handshake.
// PARAMETERS
//  DATA_W  32  register/operand width
//  ADDR_W  5   register index width (32 architectural registers)
// PORTS
//  clk           in   1       clock
//  rst           in   1       reset; synchronous, active-high
//  flush         in   1       drop held instruction (branch redirect)
//  in_valid      in   1       fetch offers instruction
//  in_ready      out  1       stage accepts instruction
//  in_pc         in   32      pc of offered instruction
//  in_inst       in   32      offered instruction word
//  rf_rs1_s      out  ADDR_W  regfile read address 1
//  rf_rs2_s      out  ADDR_W  regfile read address 2
//  rf_rs1_v      in   DATA_W  regfile read data 1 (1-cycle registered)
//  rf_rs2_v      in   DATA_W  regfile read data 2 (1-cycle registered)
//  wb_we         in   1       writeback writes regfile this cycle
//  wb_rd_s       in   ADDR_W  writeback destination
//  wb_rd_v       in   DATA_W  writeback data
//  out_valid     out  1       operands valid to execute
//  out_ready     in   1       execute accepts
//  out_pc        out  32      pc of held instruction
//  out_inst      out  32      held instruction word
//  out_rs1_v     out  DATA_W  resolved rs1 operand
//  out_rs2_v     out  DATA_W  resolved rs2 operand
// BEHAVIOUR
//  - Reset: s1_valid=0, out_valid=0, in_ready=0 during rst, out_pc/out_inst=0, forward flags=0.
//  - Single stage register S1 {valid, pc, inst, fwd1, fwd2, fwd1_v, fwd2_v}.
//  - Pipelining:
//    - adv = !s1_valid || out_ready; in_ready = adv && !rst.
//    - Accept when in_valid && in_ready. S1 loads pc/inst and valid = in_valid && !flush.
//    - Latency in->out = 1 cycle; full throughput (1 instr/cycle) when out_ready stays 1.
//  - Address select (combinational):
//    - when adv: rf_rs*_s = in_inst[19:15]/[24:20];
//    - else: the S1 inst fields.
//    - While stalled, addresses are re-issued every cycle so rf_rs*_v stays current.
//  - Bypass: the regfile returns the old value if a write and a read of the same index fall in the same cycle.
//    - Each cycle, for each port: fwdN <= wb_we && wb_rd_s!=0 && wb_rd_s==rf_rsN_s; fwdN_v <= wb_rd_v.
//    - out_rsN_v = !out_valid ? 0 : fwdN ? fwdN_v : rf_rsN_v.
//  - x0: index 0 never forwarded; the regfile returns 0.
//  - out_valid = s1_valid. out_pc/out_inst are held stable while out_valid && !out_ready.
//  - Flush: s1_valid <= 0 next cycle, and any instruction accepted in the flush cycle is discarded.
//    - in_ready behaves normally during flush.
//  - Simultaneous accept + drain: both happen in the same cycle (no bubble).
//  - Reset mid-operation: the held instruction is lost. No handshake fires in the rst cycle.
//  - rs2 field is read for every format; unused operands are don't-care downstream.
// CONFIGURATION
//  OPERAND_FETCH_PERF_EN
//    - defined: extra output perf_stall_cnt[31:0] counts cycles with out_valid && !out_ready.
//      Saturates at 32'hFFFF_FFFF; cleared by rst.
//    - undefined: the port and counter do not exist. All other behaviour is identical.
// TESTING
//  1. Reset held 2 cycles, then released -> out_valid=0, in_ready=1 first cycle after release, out_rs*_v=0.
//  2. Back-to-back addi x1 and add x3,x1,x2 (x1=5, x2=7 preloaded), out_ready=1
//     -> one result per cycle; operands {5,7} on the second.
//  3. wb writes x1=0xDEAD in the same cycle an instruction reading x1 is accepted
//     -> out_rs1_v=0xDEAD next cycle, not the stale value.
//  4. out_ready=0 for 3 cycles while held instr reads x2; wb writes x2=0x55 in stall cycle 2
//     -> out_pc/out_inst stable; out_rs2_v=0x55 from stall cycle 3 on; in_ready=0 throughout.
//  5. flush asserted with s1_valid=1 and in_valid=1 -> out_valid=0 next cycle; neither instruction ever appears.
//  6. wb_we=1, wb_rd_s=0, wb_rd_v=0xFFFF_FFFF while reading x0 -> out_rs1_v=0.
//     With PERF_EN: 4 stall cycles -> perf_stall_cnt=4.

Source files
------------

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: drives regfile read addresses, patches the missing write bypass,
// and hands {pc, inst, rs1, rs2} to execute. Define OPERAND_FETCH_PERF_EN for the stall counter.
module operand_fetch #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_inst,
    output logic [ADDR_W-1:0] rf_rs1_s,
    output logic [ADDR_W-1:0] rf_rs2_s,
    input  logic [DATA_W-1:0] rf_rs1_v,
    input  logic [DATA_W-1:0] rf_rs2_v,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_rd_s,
    input  logic [DATA_W-1:0] wb_rd_v,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst,
    output logic [DATA_W-1:0] out_rs1_v,
    output logic [DATA_W-1:0] out_rs2_v
`ifdef OPERAND_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt
`endif
);

    logic              adv;
    logic              accept;
    logic              s1_valid_q;
    logic [31:0]       s1_pc_q;
    logic [31:0]       s1_inst_q;
    logic              fwd1_q;
    logic              fwd2_q;
    logic [DATA_W-1:0] fwd1_v_q;
    logic [DATA_W-1:0] fwd2_v_q;

    always_comb begin
        adv      = !s1_valid_q || out_ready;
        in_ready = adv && !rst;
        accept   = in_valid && in_ready;
        // While stalled, re-issue the held instruction's indices so the read data stays current.
        rf_rs1_s = adv ? in_inst[15 +: ADDR_W] : s1_inst_q[15 +: ADDR_W];
        rf_rs2_s = adv ? in_inst[20 +: ADDR_W] : s1_inst_q[20 +: ADDR_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_pc_q    <= '0;
            s1_inst_q  <= '0;
        end else begin
            if (adv) begin
                s1_valid_q <= accept && !flush;
            end else if (flush) begin
                s1_valid_q <= 1'b0;
            end
            if (accept) begin
                s1_pc_q   <= in_pc;
                s1_inst_q <= in_inst;
            end
        end
    end

    // The regfile returns the pre-write value on a same-cycle write/read; remember the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd1_q   <= 1'b0;
            fwd2_q   <= 1'b0;
            fwd1_v_q <= '0;
            fwd2_v_q <= '0;
        end else begin
            fwd1_q   <= wb_we && (wb_rd_s != '0) && (wb_rd_s == rf_rs1_s);
            fwd2_q   <= wb_we && (wb_rd_s != '0) && (wb_rd_s == rf_rs2_s);
            fwd1_v_q <= wb_rd_v;
            fwd2_v_q <= wb_rd_v;
        end
    end

    always_comb begin
        out_valid = s1_valid_q;
        out_pc    = s1_pc_q;
        out_inst  = s1_inst_q;
        out_rs1_v = !s1_valid_q ? '0 : (fwd1_q ? fwd1_v_q : rf_rs1_v);
        out_rs2_v = !s1_valid_q ? '0 : (fwd2_q ? fwd2_v_q : rf_rs2_v);
    end

`ifdef OPERAND_FETCH_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (s1_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch with a behavioural registered-read regfile.
module tb_operand_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic [4:0]  rf_rs1_s;
    logic [4:0]  rf_rs2_s;
    logic [31:0] rf_rs1_v;
    logic [31:0] rf_rs2_v;
    logic        wb_we;
    logic [4:0]  wb_rd_s;
    logic [31:0] wb_rd_v;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [31:0] out_rs1_v;
    logic [31:0] out_rs2_v;
`ifdef OPERAND_FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    operand_fetch #(
        .DATA_W(32),
        .ADDR_W(5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pc    (in_pc),
        .in_inst  (in_inst),
        .rf_rs1_s (rf_rs1_s),
        .rf_rs2_s (rf_rs2_s),
        .rf_rs1_v (rf_rs1_v),
        .rf_rs2_v (rf_rs2_v),
        .wb_we    (wb_we),
        .wb_rd_s  (wb_rd_s),
        .wb_rd_v  (wb_rd_v),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc   (out_pc),
        .out_inst (out_inst),
        .out_rs1_v(out_rs1_v),
        .out_rs2_v(out_rs2_v)
`ifdef OPERAND_FETCH_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // Regfile: registered reads, no internal bypass, x0 hardwired, x1=5 x2=7 after reset.
    logic [31:0] mem [32];
    always @(posedge clk) begin
        rf_rs1_v <= mem[rf_rs1_s];
        rf_rs2_v <= mem[rf_rs2_s];
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= (i == 1) ? 32'd5 : (i == 2) ? 32'd7 : 32'd0;
            end
        end else if (wb_we && wb_rd_s != 5'd0) begin
            mem[wb_rd_s] <= wb_rd_v;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        sb_q.push_back('{pc: pc, inst: inst, rs1: rs1, rs2: rs2});
    endtask

    // Monitor: every completed output handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual_pc=%h required=none", out_pc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_pc", out_pc, e.pc);
                chk("sb_inst", out_inst, e.inst);
                chk("sb_rs1", out_rs1_v, e.rs1);
                chk("sb_rs2", out_rs2_v, e.rs2);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        wb_we     = 1'b0;
        wb_rd_s   = '0;
        wb_rd_v   = '0;
        out_ready = 1'b1;

        // Reset held for two clock edges
        step();
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        rst = 1'b0;

        // addi x1,x0,1 then add x3,x1,x2 back to back
        issue(32'h100, 32'h0010_0093, 32'd0, 32'd5);
        @(negedge clk);
        chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("post_rst_rs1", out_rs1_v, 32'd0);
        chk("post_rst_rs2", out_rs2_v, 32'd0);
        chk("post_rst_pc", out_pc, 32'd0);
        chk("post_rst_inst", out_inst, 32'd0);
        step();
        issue(32'h104, 32'h0020_81B3, 32'd5, 32'd7);
        @(negedge clk);
        chk("b2b_in_ready", {31'b0, in_ready}, 32'd1);
        step();

        // add x4,x1,x0 accepted while wb writes x1=0xDEAD
        issue(32'h108, 32'h0000_8233, 32'h0000_DEAD, 32'd0);
        wb_we   = 1'b1;
        wb_rd_s = 5'd1;
        wb_rd_v = 32'h0000_DEAD;
        step();
        wb_we = 1'b0;

        // add x5,x0,x2 then stall 3 cycles, x2=0x55 written in stall cycle 2
        issue(32'h200, 32'h0020_02B3, 32'd0, 32'h55);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("stall1_out_valid", {31'b0, out_valid}, 32'd1);
        chk("stall1_in_ready", {31'b0, in_ready}, 32'd0);
        chk("stall1_pc", out_pc, 32'h200);
        chk("stall1_rs2", out_rs2_v, 32'd7);
        step();
        wb_we   = 1'b1;
        wb_rd_s = 5'd2;
        wb_rd_v = 32'h55;
        @(negedge clk);
        chk("stall2_in_ready", {31'b0, in_ready}, 32'd0);
        chk("stall2_pc", out_pc, 32'h200);
        chk("stall2_inst", out_inst, 32'h0020_02B3);
        step();
        wb_we = 1'b0;
        @(negedge clk);
        chk("stall3_in_ready", {31'b0, in_ready}, 32'd0);
        chk("stall3_pc", out_pc, 32'h200);
        chk("stall3_inst", out_inst, 32'h0020_02B3);
        chk("stall3_rs2", out_rs2_v, 32'h55);
        step();
        out_ready = 1'b1;
        step();

        // Flush with a held instruction and another one offered: neither may complete
        in_valid  = 1'b1;
        in_pc     = 32'h300;
        in_inst   = 32'h0010_8113;
        out_ready = 1'b0;
        step();
        in_pc   = 32'h304;
        in_inst = 32'h0000_0093;
        flush   = 1'b1;
        @(negedge clk);
        chk("flush_pre_valid", {31'b0, out_valid}, 32'd1);
        step();
        // Instruction accepted during a flush cycle is discarded
        in_pc     = 32'h308;
        in_inst   = 32'h0000_0113;
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_accept_dropped", {31'b0, out_valid}, 32'd0);
        step();

        // Writes to x0 never forwarded
        issue(32'h400, 32'h0000_0013, 32'd0, 32'd0);
        wb_we   = 1'b1;
        wb_rd_s = 5'd0;
        wb_rd_v = 32'hFFFF_FFFF;
        step();
        in_valid = 1'b0;
        wb_we    = 1'b0;

        // Bounded drain
        for (int i = 0; i < 4; i++) step();
        chk("sb_left", sb_q.size(), 32'd0);
`ifdef OPERAND_FETCH_PERF_EN
        chk("perf_stall_cnt", perf_stall_cnt, 32'd4);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
